writeback_unit: RTL and testbench



---
 rtl/writeback_unit_pkg.sv | 14 +
 rtl/writeback_unit_if.sv | 51 +++++
 rtl/writeback_unit_load_fifo.sv | 48 ++++
 rtl/writeback_unit.sv | 108 ++++++++++
 tb/tb_writeback_unit.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared types and sizes for the integer writeback path of the RV32I core.
package writeback_unit_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Decode, ALU, load and register-file write signals of the writeback unit.
interface writeback_unit_if #(
  parameter int XLEN = writeback_unit_pkg::XLEN
);
  import writeback_unit_pkg::*;

  // Decode side: issue scoreboarding and source hazards
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  issue_ready;
  logic [REG_ADDR_W-1:0] rs_1;
  logic [REG_ADDR_W-1:0] rs_2;
  logic                  hazard_1;
  logic                  hazard_2;

  // Single-cycle ALU result channel
  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;

  // Multi-cycle load result channel
  logic                  ld_valid;
  logic                  ld_ready;
  logic [REG_ADDR_W-1:0] ld_rd;
  logic [XLEN-1:0]       ld_data;

  // Register file write port
  logic [REG_ADDR_W-1:0] register_write;
  logic [XLEN-1:0]       write_data;
  logic                  register_write_enable;

  // Producer side (decode, ALU, load unit, register file)
  modport master (
    output issue_valid, issue_rd, rs_1, rs_2,
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    input  issue_ready, hazard_1, hazard_2, alu_ready, ld_ready,
    input  register_write, write_data, register_write_enable
  );

  // Writeback unit side
  modport slave (
    input  issue_valid, issue_rd, rs_1, rs_2,
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    output issue_ready, hazard_1, hazard_2, alu_ready, ld_ready,
    output register_write, write_data, register_write_enable
  );

endinterface

// File: rtl/writeback_unit_load_fifo.sv
// Small synchronous FIFO buffering load results until the write port is free.
module writeback_unit_load_fifo
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // The extra pointer MSB tells a full wrap apart from an empty FIFO.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards all queued entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Entry storage; contents are qualified by the pointers so need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/writeback_unit.sv
// Integer register-file writeback: ALU/load arbitration, output register and
// the pending-destination scoreboard used by decode for RAW/WAW detection.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int XLEN            = writeback_unit_pkg::XLEN,
  parameter int LOAD_FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  writeback_unit_if.slave bus
);

  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   set_mask;
  logic [NUM_REGS-1:0]   clr_mask;
  logic                  issue_ok;

  wb_entry_t             alu_entry;
  wb_entry_t             ld_entry;
  wb_entry_t             head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  alu_take;

  wb_entry_t             sel_p0;
  logic                  vld_p0;

  logic [REG_ADDR_W-1:0] wr_rd_p1;
  logic [XLEN-1:0]       wr_data_p1;
  logic                  vld_p1;

  // ---- p0: select one result for the write port ----
  assign fifo_push     = bus.ld_valid && !fifo_full;
  assign bus.ld_ready  = !fifo_full;
  assign bus.alu_ready = !fifo_full;

  writeback_unit_load_fifo #(.DEPTH(LOAD_FIFO_DEPTH)) u_load_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (ld_entry),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ALU wins unless the load FIFO is full, which forces a drain so loads never starve.
  always_comb begin
    alu_entry.rd   = bus.alu_rd;
    alu_entry.data = bus.alu_data;
    ld_entry.rd    = bus.ld_rd;
    ld_entry.data  = bus.ld_data;
    alu_take       = bus.alu_valid && !fifo_full;
    fifo_pop       = !fifo_empty && (fifo_full || !bus.alu_valid);
    vld_p0         = alu_take || fifo_pop;
    sel_p0         = alu_take ? alu_entry : head;
  end

  // ---- p1: registered register-file write port ----
  // Writes to x0 are consumed but never strobe the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      wr_rd_p1   <= '0;
      wr_data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0 && (sel_p0.rd != '0);
      if (vld_p0) begin
        wr_rd_p1   <= sel_p0.rd;
        wr_data_p1 <= sel_p0.data;
      end
    end
  end

  assign bus.register_write        = wr_rd_p1;
  assign bus.write_data            = wr_data_p1;
  assign bus.register_write_enable = vld_p1;

  // Scoreboard: issue sets, the write leaving p1 clears; set is applied last so it wins.
  assign issue_ok        = !pending[bus.issue_rd] || (bus.issue_rd == '0);
  assign bus.issue_ready = issue_ok;

  // Per-register set/clear requests for this edge.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.issue_valid && issue_ok && (bus.issue_rd != '0)) set_mask[bus.issue_rd] = 1'b1;
    if (vld_p1) clr_mask[wr_rd_p1] = 1'b1;
  end

  // Pending bits; x0 is never pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= {((pending[NUM_REGS-1:1] & ~clr_mask[NUM_REGS-1:1]) | set_mask[NUM_REGS-1:1]), 1'b0};
    end
  end

  // A source is hazardous while its write is outstanding, including the write cycle itself.
  assign bus.hazard_1 = (pending[bus.rs_1] || (vld_p1 && (wr_rd_p1 == bus.rs_1))) && (bus.rs_1 != '0);
  assign bus.hazard_2 = (pending[bus.rs_2] || (vld_p1 && (wr_rd_p1 == bus.rs_2))) && (bus.rs_2 != '0);

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus queues expected writes,
// a negedge monitor pops and compares every register-file write strobe.
module tb_writeback_unit;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  writeback_unit_if bus ();

  writeback_unit #(.XLEN(32), .LOAD_FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.alu_valid   = 1'b0;
    bus.ld_valid    = 1'b0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [31:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_rd    = rd;
    bus.ld_data  = d;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.register_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%08h, expected no write",
                 bus.register_write, bus.write_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_rd", 32'(bus.register_write), 32'(e.rd));
        chk("wr_data", bus.write_data, e.data);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    bus.issue_rd = '0; bus.rs_1 = '0; bus.rs_2 = '0;
    bus.alu_rd = '0; bus.alu_data = '0; bus.ld_rd = '0; bus.ld_data = '0;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_rd    = 5'($urandom_range(0, 31));
      bus.rs_1        = 5'($urandom_range(0, 31));
      bus.rs_2        = 5'($urandom_range(0, 31));
      bus.alu_valid   = 1'($urandom_range(0, 1));
      bus.alu_rd      = 5'($urandom_range(0, 31));
      bus.alu_data    = $urandom;
      bus.ld_valid    = 1'($urandom_range(0, 1));
      bus.ld_rd       = 5'($urandom_range(0, 31));
      bus.ld_data     = $urandom;
      #1;
      chk("rst_wen", 32'(bus.register_write_enable), 32'd0);
      chk("rst_rd", 32'(bus.register_write), 32'd0);
      chk("rst_data", bus.write_data, 32'd0);
      chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
      chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
      chk("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
      chk("rst_hazard_1", 32'(bus.hazard_1), 32'd0);
      chk("rst_hazard_2", 32'(bus.hazard_2), 32'd0);
    end
    idle();
    bus.issue_rd = '0; bus.rs_1 = '0; bus.rs_2 = '0;
    cyc();
    rst_n = 1'b1;

    // Issue rd=5 then ALU write of 0xDEADBEEF to x5
    cyc();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.rs_1 = 5'd5;
    #1;
    chk("issue5_ready", 32'(bus.issue_ready), 32'd1);
    chk("haz1_before_issue", 32'(bus.hazard_1), 32'd0);
    cyc();
    bus.issue_valid = 1'b0;
    alu(5'd5, 32'hDEADBEEF);
    expect_wr(5'd5, 32'hDEADBEEF);
    #1;
    chk("haz1_pending", 32'(bus.hazard_1), 32'd1);
    chk("issue5_blocked", 32'(bus.issue_ready), 32'd0);
    chk("alu_ready_5", 32'(bus.alu_ready), 32'd1);
    cyc();
    idle();
    #1;
    chk("haz1_write_cycle", 32'(bus.hazard_1), 32'd1);
    chk("wen_x5", 32'(bus.register_write_enable), 32'd1);
    cyc();
    #1;
    chk("haz1_cleared", 32'(bus.hazard_1), 32'd0);
    chk("issue5_free", 32'(bus.issue_ready), 32'd1);
    chk("wen_one_cycle", 32'(bus.register_write_enable), 32'd0);

    // Load and ALU in the same cycle: ALU first, load next
    cyc();
    alu(5'd4, 32'h0000_0044);
    ld(5'd3, 32'h0000_0033);
    expect_wr(5'd4, 32'h0000_0044);
    expect_wr(5'd3, 32'h0000_0033);
    #1;
    chk("collide_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("collide_ld_ready", 32'(bus.ld_ready), 32'd1);
    cyc(); idle();
    cyc(); cyc();

    // Continuous ALU traffic while two loads fill the FIFO
    cyc();
    alu(5'd10, 32'hA0); ld(5'd6, 32'h66);
    expect_wr(5'd10, 32'hA0);
    #1;
    chk("fill_ld_ready_0", 32'(bus.ld_ready), 32'd1);
    cyc();
    alu(5'd11, 32'hA1); ld(5'd7, 32'h77);
    expect_wr(5'd11, 32'hA1);
    #1;
    chk("fill_ld_ready_1", 32'(bus.ld_ready), 32'd1);
    chk("fill_alu_ready_1", 32'(bus.alu_ready), 32'd1);
    cyc();
    alu(5'd12, 32'hA2); bus.ld_valid = 1'b0;
    expect_wr(5'd6, 32'h66);
    #1;
    chk("full_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("full_alu_stalled", 32'(bus.alu_ready), 32'd0);
    cyc();
    expect_wr(5'd12, 32'hA2);
    #1;
    chk("drain_alu_resumes", 32'(bus.alu_ready), 32'd1);
    chk("drain_ld_ready", 32'(bus.ld_ready), 32'd1);
    cyc();
    idle();
    expect_wr(5'd7, 32'h77);
    #1;
    chk("idle_alu_ready", 32'(bus.alu_ready), 32'd1);
    cyc(); cyc();

    // Write to x0 is consumed without a strobe; issue_rd=0 never blocks
    cyc();
    alu(5'd0, 32'h1);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.rs_2 = 5'd0;
    #1;
    chk("x0_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("x0_issue_ready", 32'(bus.issue_ready), 32'd1);
    chk("x0_hazard_2", 32'(bus.hazard_2), 32'd0);
    cyc();
    bus.alu_valid = 1'b0;
    #1;
    chk("x0_no_wen", 32'(bus.register_write_enable), 32'd0);
    chk("x0_issue_again", 32'(bus.issue_ready), 32'd1);
    cyc(); idle();

    // WAW: second issue of rd=9 stalls until x9 is written
    cyc();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    #1;
    chk("waw_first", 32'(bus.issue_ready), 32'd1);
    cyc();
    alu(5'd9, 32'h99);
    expect_wr(5'd9, 32'h99);
    #1;
    chk("waw_second_blocked", 32'(bus.issue_ready), 32'd0);
    cyc();
    bus.alu_valid = 1'b0;
    #1;
    chk("waw_blocked_write_cycle", 32'(bus.issue_ready), 32'd0);
    chk("waw_wen", 32'(bus.register_write_enable), 32'd1);
    cyc();
    #1;
    chk("waw_released", 32'(bus.issue_ready), 32'd1);
    cyc();
    idle();
    bus.rs_2 = 5'd9;
    #1;
    chk("waw_reissued_hazard", 32'(bus.hazard_2), 32'd1);
    chk("waw_reissued_block", 32'(bus.issue_ready), 32'd0);

    // Reset mid-flight with two loads queued and a write in the output register
    cyc();
    alu(5'd20, 32'h20); ld(5'd21, 32'h21);
    expect_wr(5'd20, 32'h20);
    cyc();
    alu(5'd22, 32'h22); ld(5'd23, 32'h23);
    cyc();
    rst_n = 1'b0;
    idle();
    #1;
    chk("midrst_wen", 32'(bus.register_write_enable), 32'd0);
    chk("midrst_rd", 32'(bus.register_write), 32'd0);
    chk("midrst_data", bus.write_data, 32'd0);
    chk("midrst_hazard_2", 32'(bus.hazard_2), 32'd0);
    chk("midrst_ld_ready", 32'(bus.ld_ready), 32'd1);
    cyc(); cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1;
      chk("postrst_no_write", 32'(bus.register_write_enable), 32'd0);
    end
    chk("postrst_issue9", 32'(bus.issue_ready), 32'd1);
    chk("postrst_hazard_2", 32'(bus.hazard_2), 32'd0);

    // Normal operation after reset
    cyc();
    alu(5'd1, 32'h0000_1234);
    expect_wr(5'd1, 32'h0000_1234);
    cyc(); idle();
    cyc(); cyc();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
